// File: rtl/tx_frame_scheduler_pkg.sv
// Shared definitions for the transmit frame scheduler.
//   BYTE_W         : width of one transmitted byte
//   DEFAULT_HEADER : frame sync word, low byte goes out first
//   state_e        : scheduler FSM state encoding
package tx_frame_scheduler_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam logic [15:0] DEFAULT_HEADER = 16'hAA55;

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StPay,
        StCsum,
        StGap
    } state_e;

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter with a last-served pointer.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous, active-high; pointer returns to favouring source 0
//   req     : request per source
//   advance : a grant is being taken this cycle; pointer records the winner
//   pick    : one-hot winner (all zero when nothing requests)
module tx_frame_scheduler_rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] pick
);

    // 1 = source 1 was served last. Resetting to 1 makes source 0 win the first tie.
    logic last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (advance && (req != 2'b00)) begin
            last_q <= pick[1];
        end
    end

    always_comb begin
        pick = 2'b00;
        unique case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_q ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Shares one byte-level UART transmitter between two report sources
// (source 0 = distance report, source 1 = status/heartbeat). A round-robin
// grant latches the winner's payload, then the frame goes out as
// HEADER[7:0], HEADER[15:8], payload bytes LSB-first, 8-bit sum checksum.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   enable      : 0 blocks new grants; a running frame completes
//   req         : level request per source
//   data0/data1 : source payloads, sampled at the grant edge
//   gnt         : one-cycle pulse, payload of that source was latched
//   frame_done  : one-cycle pulse after the checksum byte was accepted
//   byte_out    : byte to the UART, qualified by byte_valid
//   byte_ready  : UART accepts byte_out this cycle
//   busy        : FSM is not idle
//   active_src  : source of the current or last frame
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter logic [15:0] HEADER        = DEFAULT_HEADER,
    parameter int unsigned PAYLOAD_BYTES = 6,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [1:0]                      req,
    input  logic [PAYLOAD_BYTES*BYTE_W-1:0] data0,
    input  logic [PAYLOAD_BYTES*BYTE_W-1:0] data1,
    output logic [1:0]                      gnt,
    output logic                            frame_done,
    output logic [BYTE_W-1:0]               byte_out,
    output logic                            byte_valid,
    input  logic                            byte_ready,
    output logic                            busy,
    output logic                            active_src
);

    localparam int unsigned IdxW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(PAYLOAD_BYTES - 1);
    localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e                                   state_q, state_d;
    logic [PAYLOAD_BYTES-1:0][BYTE_W-1:0]     payload_q, payload_d;
    logic [IdxW-1:0]                          idx_q, idx_d;
    logic [GapW-1:0]                          gap_q, gap_d;
    logic [BYTE_W-1:0]                        csum_q, csum_d;
    logic [1:0]                               gnt_q, gnt_d;
    logic                                     done_q, done_d;
    logic                                     src_q, src_d;
    logic [1:0]                               pick;
    logic                                     advance;

    tx_frame_scheduler_rr_arbiter2 u_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (advance),
        .pick    (pick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            payload_q <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            csum_q    <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            src_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            csum_q    <= csum_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            src_q     <= src_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        payload_d  = payload_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        csum_d     = csum_q;
        gnt_d      = 2'b00;
        done_d     = 1'b0;
        src_d      = src_q;
        advance    = 1'b0;
        byte_valid = 1'b0;
        byte_out   = '0;

        unique case (state_q)
            StIdle: begin
                if (enable && (req != 2'b00)) begin
                    advance   = 1'b1;
                    gnt_d     = pick;
                    src_d     = pick[1];
                    payload_d = pick[1] ? data1 : data0;
                    idx_d     = '0;
                    csum_d    = '0;
                    state_d   = StHdr0;
                end
            end
            StHdr0: begin
                byte_valid = 1'b1;
                byte_out   = HEADER[7:0];
                if (byte_ready) begin
                    state_d = StHdr1;
                end
            end
            StHdr1: begin
                byte_valid = 1'b1;
                byte_out   = HEADER[15:8];
                if (byte_ready) begin
                    state_d = StPay;
                end
            end
            StPay: begin
                byte_valid = 1'b1;
                byte_out   = payload_q[idx_q];
                if (byte_ready) begin
                    csum_d = csum_q + payload_q[idx_q];
                    if (idx_q == IdxLast) begin
                        state_d = StCsum;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StCsum: begin
                byte_valid = 1'b1;
                byte_out   = csum_q;
                if (byte_ready) begin
                    done_d = 1'b1;
                    csum_d = '0;
                    gap_d  = '0;
                    // A zero-length gap skips straight back to idle.
                    state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign gnt        = gnt_q;
    assign frame_done = done_q;
    assign busy       = (state_q != StIdle);
    assign active_src = src_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
module tb_tx_frame_scheduler;

    localparam int unsigned PB = 6;
    localparam int unsigned GC = 2;

    logic        clk = 1'b0;
    logic        reset, enable, byte_ready;
    logic [1:0]  req;
    logic [47:0] data0, data1;
    logic [1:0]  gnt;
    logic        frame_done, byte_valid, busy, active_src;
    logic [7:0]  byte_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0] log_q[$];
    int g0_cnt   = 0;
    int g1_cnt   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    tx_frame_scheduler #(
        .HEADER        (16'hAA55),
        .PAYLOAD_BYTES (PB),
        .GAP_CYCLES    (GC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .gnt        (gnt),
        .frame_done (frame_done),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .active_src (active_src)
    );

    // Monitor mid-cycle: accepted bytes and pulse counts.
    always @(negedge clk) begin
        if (byte_valid === 1'b1 && byte_ready === 1'b1) log_q.push_back(byte_out);
        if (gnt[0] === 1'b1) g0_cnt++;
        if (gnt[1] === 1'b1) g1_cnt++;
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_done(input string name, input int max);
        int start;
        bit ok;
        start = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: frame_done not seen within %0d cycles", name, max);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; req = 2'b00; byte_ready = 1'b1;
        data0 = '0; data1 = '0;
        idle(3);
        checks++;
        if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        checks++;
        if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", frame_done); end
        checks++;
        if (byte_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", byte_valid); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (active_src !== 1'b0) begin failures++; $display("FAIL reset_src: got %b want 0", active_src); end
        checks++;
        if (byte_out !== 8'h00) begin failures++; $display("FAIL reset_byte: got %h want 00", byte_out); end
        reset = 1'b0;
        tick();
    endtask

    // T1: single src0 frame with hand-computed bytes and checksum.
    task automatic test_single();
        logic [7:0] exp [0:8];
        int base, g0, g1, d;
        exp = '{8'h55, 8'hAA, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h15};
        base = log_q.size(); g0 = g0_cnt; g1 = g1_cnt; d = done_cnt;
        enable = 1'b1; byte_ready = 1'b1; data0 = 48'h010203040506; req = 2'b01;
        tick();
        checks++;
        if (gnt !== 2'b01 || byte_valid !== 1'b1 || byte_out !== 8'h55) begin
            failures++;
            $display("FAIL t1_latency: gnt=%b valid=%b byte=%h want 01 1 55", gnt, byte_valid, byte_out);
        end
        req = 2'b00;
        wait_done("t1_done", 40);
        idle(4);
        checks++;
        if (log_q.size() - base !== 9) begin
            failures++; $display("FAIL t1_count: got %0d bytes want 9", log_q.size() - base);
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (log_q[base+i] !== exp[i]) begin
                    failures++; $display("FAIL t1_byte%0d: got %h want %h", i, log_q[base+i], exp[i]);
                end
            end
        end
        checks++;
        if (g0_cnt - g0 !== 1 || g1_cnt - g1 !== 0) begin
            failures++; $display("FAIL t1_gnt: g0=%0d g1=%0d want 1 0", g0_cnt - g0, g1_cnt - g1);
        end
        checks++;
        if (done_cnt - d !== 1) begin failures++; $display("FAIL t1_ndone: got %0d want 1", done_cnt - d); end
        checks++;
        if (busy !== 1'b0 || active_src !== 1'b0) begin
            failures++; $display("FAIL t1_end: busy=%b src=%b want 0 0", busy, active_src);
        end
    endtask

    // T2: simultaneous requests after reset, src0 then src1, gap length.
    task automatic test_both();
        logic [7:0] exp [0:17];
        bit vbits [0:29];
        int base, phase, zeros;
        exp = '{8'h55, 8'hAA, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h65,
                8'h55, 8'hAA, 8'hF0, 8'hE0, 8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'hB0};
        reset = 1'b1; tick(); reset = 1'b0;
        base = log_q.size();
        enable = 1'b1; byte_ready = 1'b1;
        data0 = 48'h112233445566; data1 = 48'hA0B0C0D0E0F0; req = 2'b11;
        tick();
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL t2_first: got %b want 01", gnt); end
        req = 2'b10;
        for (int i = 0; i < 30; i++) begin
            vbits[i] = byte_valid;
            if (gnt[1] === 1'b1) req = 2'b00;
            tick();
        end
        idle(4);
        phase = 0; zeros = 0;
        for (int i = 0; i < 30; i++) begin
            if (phase == 0 && !vbits[i]) begin phase = 1; zeros = 1; end
            else if (phase == 1) begin
                if (vbits[i]) phase = 2;
                else zeros++;
            end
        end
        checks++;
        if (phase != 2 || zeros != GC + 1) begin
            failures++; $display("FAIL t2_gap: got %0d idle cycles (phase %0d) want %0d", zeros, phase, GC + 1);
        end
        checks++;
        if (log_q.size() - base !== 18) begin
            failures++; $display("FAIL t2_count: got %0d bytes want 18", log_q.size() - base);
        end else begin
            for (int i = 0; i < 18; i++) begin
                checks++;
                if (log_q[base+i] !== exp[i]) begin
                    failures++; $display("FAIL t2_byte%0d: got %h want %h", i, log_q[base+i], exp[i]);
                end
            end
        end
        checks++;
        if (active_src !== 1'b1) begin failures++; $display("FAIL t2_src: got %b want 1", active_src); end
    endtask

    // T3: checksum wrap, then a 5-cycle stall mid-payload.
    task automatic test_backpressure();
        logic [7:0] exp [0:8];
        int base;
        exp = '{8'h55, 8'hAA, 8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h4B};
        base = log_q.size();
        enable = 1'b1; byte_ready = 1'b1; data0 = {6{8'hFF}}; req = 2'b01;
        tick();
        req = 2'b00;
        wait_done("t3_wrap_done", 40);
        idle(4);
        checks++;
        if (log_q.size() - base !== 9 || log_q[log_q.size()-1] !== 8'hFA) begin
            failures++;
            $display("FAIL t3_wrap: got %0d bytes last %h want 9 FA", log_q.size() - base, log_q[log_q.size()-1]);
        end
        base = log_q.size();
        data0 = 48'h0A0B0C0D0E0F; req = 2'b01;
        tick();
        req = 2'b00;
        idle(4);
        checks++;
        if (byte_out !== 8'h0D) begin failures++; $display("FAIL t3_pre_stall: got %h want 0D", byte_out); end
        byte_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (byte_valid !== 1'b1 || byte_out !== 8'h0D) begin
                failures++; $display("FAIL t3_stall%0d: valid=%b byte=%h want 1 0D", k, byte_valid, byte_out);
            end
        end
        byte_ready = 1'b1;
        wait_done("t3_stall_done", 40);
        idle(4);
        checks++;
        if (log_q.size() - base !== 9) begin
            failures++; $display("FAIL t3_count: got %0d bytes want 9", log_q.size() - base);
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (log_q[base+i] !== exp[i]) begin
                    failures++; $display("FAIL t3_byte%0d: got %h want %h", i, log_q[base+i], exp[i]);
                end
            end
        end
    endtask

    // T4: reset during payload byte 3 aborts; pointer and checksum restart.
    task automatic test_reset_mid();
        logic [7:0] exp [0:8];
        int base, d;
        exp = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        enable = 1'b1; byte_ready = 1'b1; data0 = 48'h112233445566; req = 2'b01;
        tick();
        req = 2'b00;
        idle(5);
        checks++;
        if (byte_out !== 8'h33) begin failures++; $display("FAIL t4_pos: got %h want 33", byte_out); end
        d = done_cnt;
        reset = 1'b1;
        tick();
        checks++;
        if (byte_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL t4_abort: valid=%b busy=%b want 0 0", byte_valid, busy);
        end
        reset = 1'b0;
        idle(5);
        checks++;
        if (done_cnt !== d) begin failures++; $display("FAIL t4_nodone: got %0d pulses want 0", done_cnt - d); end
        base = log_q.size();
        data0 = 48'h000000000001; data1 = 48'h0000000000FF; req = 2'b11;
        tick();
        checks++;
        if (gnt !== 2'b01 || byte_out !== 8'h55) begin
            failures++; $display("FAIL t4_restart: gnt=%b byte=%h want 01 55", gnt, byte_out);
        end
        req = 2'b00;
        wait_done("t4_done", 40);
        idle(4);
        checks++;
        if (log_q.size() - base !== 9) begin
            failures++; $display("FAIL t4_count: got %0d bytes want 9", log_q.size() - base);
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (log_q[base+i] !== exp[i]) begin
                    failures++; $display("FAIL t4_byte%0d: got %h want %h", i, log_q[base+i], exp[i]);
                end
            end
        end
    endtask

    // T5: enable low blocks grants but not a frame already running.
    task automatic test_enable();
        logic [7:0] exp [0:8];
        int base;
        exp = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
        enable = 1'b0; byte_ready = 1'b1; data0 = 48'h060504030201; req = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (gnt !== 2'b00 || busy !== 1'b0) begin
                failures++; $display("FAIL t5_blocked%0d: gnt=%b busy=%b want 00 0", k, gnt, busy);
            end
        end
        base = log_q.size();
        enable = 1'b1;
        tick();
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL t5_grant: got %b want 01", gnt); end
        enable = 1'b0; req = 2'b00;
        wait_done("t5_done", 40);
        idle(4);
        checks++;
        if (log_q.size() - base !== 9) begin
            failures++; $display("FAIL t5_count: got %0d bytes want 9", log_q.size() - base);
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (log_q[base+i] !== exp[i]) begin
                    failures++; $display("FAIL t5_byte%0d: got %h want %h", i, log_q[base+i], exp[i]);
                end
            end
        end
        enable = 1'b1;
    endtask

    // T6: src1 alone three times, then both held high -> alternating grants.
    task automatic test_src1_rr();
        logic [1:0] expg [0:3];
        int g0, g1, ng;
        expg = '{2'b01, 2'b10, 2'b01, 2'b10};
        g0 = g0_cnt; g1 = g1_cnt;
        enable = 1'b1; byte_ready = 1'b1; data0 = 48'h0;
        for (int k = 0; k < 3; k++) begin
            data1 = {40'h0, 8'(k + 1)};
            req = 2'b10;
            tick();
            checks++;
            if (gnt !== 2'b10) begin failures++; $display("FAIL t6_src1_%0d: got %b want 10", k, gnt); end
            req = 2'b00;
            wait_done("t6_src1_done", 40);
            idle(4);
            checks++;
            if (log_q[log_q.size()-1] !== 8'(k + 1)) begin
                failures++; $display("FAIL t6_csum%0d: got %h want %h", k, log_q[log_q.size()-1], 8'(k + 1));
            end
        end
        checks++;
        if (g0_cnt - g0 !== 0 || g1_cnt - g1 !== 3) begin
            failures++; $display("FAIL t6_counts: g0=%0d g1=%0d want 0 3", g0_cnt - g0, g1_cnt - g1);
        end
        ng = 0;
        req = 2'b11;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (gnt !== 2'b00) begin
                checks++;
                if (gnt !== expg[ng]) begin
                    failures++; $display("FAIL t6_rr%0d: got %b want %b", ng, gnt, expg[ng]);
                end
                ng++;
                if (ng == 4) break;
            end
        end
        req = 2'b00;
        checks++;
        if (ng != 4) begin failures++; $display("FAIL t6_rr_timeout: got %0d grants want 4", ng); end
        wait_done("t6_rr_done", 40);
        idle(4);
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_backpressure();
        test_reset_mid();
        test_enable();
        test_src1_rr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
